// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM state type and request struct for the RW0 port arbiter.
package sram_arb_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 174;
  localparam int unsigned MASK_W = 6;
  localparam int unsigned LANE_W = 29;
  localparam int unsigned DEPTH  = 8192;

  typedef enum logic {ARB_INIT, ARB_RUN} arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } sram_req_t;

endpackage

// File: rtl/sram_rw_arbiter_if.sv
// Read/write requester bus of the RW0 arbiter; master = requesters, slave = arbiter.
interface sram_rw_arbiter_if import sram_arb_pkg::*; ();

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic [MASK_W-1:0] wr_req_mask;

  modport master (
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
    input  rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready
  );

  modport slave (
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr, wr_req_data, wr_req_mask,
    output rd_req_ready, rd_resp_valid, rd_resp_data, wr_req_ready
  );

endinterface

// File: rtl/sram_init_seq.sv
// Zero-clear sweep address counter; 'last' marks the final address, 'done' follows it.
module sram_init_seq import sram_arb_pkg::*; (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              done
);

  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (last) done_q <= 1'b1;
    end
  end

  assign last = !done_q && (cnt_q == ADDR_W'(DEPTH - 1));
  assign addr = cnt_q;
  assign done = done_q;

endmodule

// File: rtl/sram_rw_arbiter.sv
// Single RW0 port arbiter: write priority with bounded read starvation, 1-cycle read response.
// Define SRAM_ARB_INIT_EN to run a zero-clear sweep of the whole array after reset.
module sram_rw_arbiter import sram_arb_pkg::*; #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  sram_rw_arbiter_if.slave  bus,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic            run;
  logic            starve_hit;
  logic            wr_fire;
  logic            rd_fire;
  logic            rd_resp_valid_q;
  logic [CntW-1:0] starve_q;
  sram_req_t       wr_req;

`ifdef SRAM_ARB_INIT_EN
  arb_state_e        state_q;
  logic [ADDR_W-1:0] init_addr;
  logic              init_last;
  logic              init_active;

  sram_init_seq u_init_seq (
    .clock (clock),
    .reset (reset),
    .addr  (init_addr),
    .last  (init_last),
    .done  (init_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARB_INIT;
    end else if (state_q == ARB_INIT && init_last) begin
      state_q <= ARB_RUN;
    end
  end

  assign run         = (state_q == ARB_RUN);
  // Keep the array idle while reset is held so sram_en reads 0 in reset.
  assign init_active = (state_q == ARB_INIT) && !reset;
`else
  logic init_done_q;

  always_ff @(posedge clock) begin
    if (reset) init_done_q <= 1'b0;
    else       init_done_q <= 1'b1;
  end

  assign run       = init_done_q;
  assign init_done = init_done_q;
`endif

  assign wr_req = '{addr: bus.wr_req_addr, data: bus.wr_req_data, mask: bus.wr_req_mask};

  always_comb begin
    starve_hit       = (starve_q == CntW'(STARVE_LIMIT));
    bus.wr_req_ready = run && !(bus.rd_req_valid && starve_hit);
    bus.rd_req_ready = run && (!bus.wr_req_valid || starve_hit);
    wr_fire          = bus.wr_req_valid && bus.wr_req_ready;
    rd_fire          = bus.rd_req_valid && bus.rd_req_ready;

    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
`ifdef SRAM_ARB_INIT_EN
    if (init_active) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_addr;
      sram_wmask = '1;
    end else
`endif
    if (wr_fire) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wr_req.addr;
      sram_wmask = wr_req.mask;
      sram_wdata = wr_req.data;
    end else if (rd_fire) begin
      sram_en   = 1'b1;
      sram_addr = bus.rd_req_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q        <= '0;
      rd_resp_valid_q <= 1'b0;
    end else begin
      rd_resp_valid_q <= rd_fire;
      if (rd_fire) begin
        starve_q <= '0;
      end else if (bus.rd_req_valid && wr_fire && !starve_hit) begin
        starve_q <= starve_q + CntW'(1);
      end
    end
  end

  // Array read is registered inside the macro, so data lines up with the valid pulse.
  assign bus.rd_resp_valid = rd_resp_valid_q;
  assign bus.rd_resp_data  = sram_rdata;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Bench for sram_rw_arbiter with a behavioural RW0 array and a reference memory model.
module tb_sram_rw_arbiter;
  import sram_arb_pkg::*;

`ifdef SRAM_ARB_INIT_EN
  localparam bit InitEn = 1'b1;
`else
  localparam bit InitEn = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              init_done;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  always #5 clock = ~clock;

  sram_rw_arbiter_if bus ();

  sram_rw_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  logic [DATA_W-1:0] mem [DEPTH];

  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int l = 0; l < MASK_W; l++) begin
          if (sram_wmask[l]) mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int                n_vec = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] ref_mem [int];
  bit                zero_filled = 1'b0;
  logic [DATA_W-1:0] last_rdata;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < MASK_W; i++) r[i*LANE_W +: LANE_W] = LANE_W'($urandom());
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_d,
                                              input logic [DATA_W-1:0] new_d,
                                              input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] bits;
    for (int l = 0; l < MASK_W; l++) bits[l*LANE_W +: LANE_W] = {LANE_W{m[l]}};
    return (old_d & ~bits) | (new_d & bits);
  endfunction

  function automatic bit ref_known(input int a);
    return ref_mem.exists(a) || zero_filled;
  endfunction

  function automatic logic [DATA_W-1:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic ref_write(input int a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    ref_mem[a] = merge(ref_get(a), d, m);
  endtask

  task automatic idle();
    bus.rd_req_valid = 1'b0;
    bus.wr_req_valid = 1'b0;
    bus.rd_req_addr  = '0;
    bus.wr_req_addr  = '0;
    bus.wr_req_data  = '0;
    bus.wr_req_mask  = '0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [MASK_W-1:0] m);
    bus.wr_req_valid = 1'b1;
    bus.wr_req_addr  = a;
    bus.wr_req_data  = d;
    bus.wr_req_mask  = m;
    #1;
    chk("wr_ready", bus.wr_req_ready, 1'b1);
    chk("wr_drive", {sram_en, sram_wmode, sram_wmask, sram_addr}, {2'b11, m, a});
    chk("wr_wdata", sram_wdata, d);
    ref_write(int'(a), d, m);
    @(negedge clock); #1;
    bus.wr_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = a;
    #1;
    chk("rd_ready", bus.rd_req_ready, 1'b1);
    chk("rd_drive", {sram_en, sram_wmode, sram_addr}, {2'b10, a});
    @(negedge clock); #1;
    chk("rd_resp_valid", bus.rd_resp_valid, 1'b1);
    last_rdata = bus.rd_resp_data;
    if (ref_known(int'(a))) chk("rd_data", bus.rd_resp_data, ref_get(int'(a)));
    bus.rd_req_valid = 1'b0;
  endtask

  // Entered right after reset release; walks the clear sweep (or the 1-cycle no-init start).
  task automatic startup(input int n, input bit full);
    if (InitEn) begin
      for (int i = 0; i < n; i++) begin
        #1;
        chk("sweep_ctl", {sram_en, sram_wmode, sram_wmask, sram_addr, init_done, bus.rd_req_ready,
                          bus.wr_req_ready}, {2'b11, 6'h3F, ADDR_W'(i), 3'b000});
        chk("sweep_wdata", sram_wdata, '0);
        @(negedge clock); #1;
      end
      if (full) begin
        #1;
        chk("init_done_rise", {init_done, sram_en, bus.rd_req_ready}, 3'b101);
        ref_mem.delete();
        zero_filled = 1'b1;
        @(negedge clock); #1;
      end
    end else begin
      #1;
      chk("noinit_first", {init_done, bus.rd_req_ready, bus.wr_req_ready, sram_en}, 4'b0000);
      @(negedge clock); #1;
      chk("noinit_run", {init_done, bus.rd_req_ready, bus.wr_req_ready}, 3'b111);
      ref_mem.delete();
      @(negedge clock); #1;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] p, q, wd;
    logic [ADDR_W-1:0] ra, wa;
    bit                prev_r;
    logic [DATA_W-1:0] prev_exp;
    int                rd_idx;

    idle();
    reset = 1'b1;
    bus.rd_req_valid = 1'b1;
    bus.wr_req_valid = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_vals", {bus.rd_resp_valid, init_done, bus.rd_req_ready, bus.wr_req_ready, sram_en},
        5'b00000);
    idle();
    reset = 1'b0;
    startup(DEPTH, 1'b1);

    if (InitEn) begin
      do_read(ADDR_W'(16'h1ABC));
      chk("cleared_1abc", last_rdata, '0);
    end

    // Full write then read-back, then a single-lane masked overwrite.
    p = rnd_data();
    q = rnd_data();
    do_write(ADDR_W'(5), p, 6'h3F);
    do_read(ADDR_W'(5));
    chk("full_wr_rd", last_rdata, p);
    do_write(ADDR_W'(5), q, 6'b000010);
    do_read(ADDR_W'(5));
    chk("masked_lane1", last_rdata, {p[173:58], q[57:29], p[28:0]});
    @(negedge clock); #1;
    chk("resp_drop", bus.rd_resp_valid, 1'b0);

    for (int i = 0; i < 16; i++) do_write(ADDR_W'(32'h100 + i), rnd_data(), 6'h3F);
    for (int i = 0; i < 40; i++) begin
      wa = ADDR_W'(32'h100 + $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) do_write(wa, rnd_data(), MASK_W'($urandom()));
      else                           do_read(wa);
    end

    // Back-to-back reads.
    for (int i = 0; i < 3; i++) do_write(ADDR_W'(32'h10 + i), rnd_data(), 6'h3F);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        chk("b2b_valid", bus.rd_resp_valid, 1'b1);
        chk("b2b_data", bus.rd_resp_data, ref_get(32'h10 + i - 1));
      end
      bus.rd_req_valid = (i < 3);
      bus.rd_req_addr  = ADDR_W'(32'h10 + i);
      if (i < 3) begin
        #1;
        chk("b2b_ready", bus.rd_req_ready, 1'b1);
      end
      @(negedge clock); #1;
    end
    chk("b2b_end", bus.rd_resp_valid, 1'b0);

    // Contention: both valid every cycle, grants must go W,W,W,W,R.
    rd_idx = 0;
    ra = ADDR_W'(32'h100);
    wa = ADDR_W'(32'h200);
    wd = rnd_data();
    prev_r = 1'b0;
    prev_exp = '0;
    for (int k = 0; k < 15; k++) begin
      chk("cont_resp_valid", bus.rd_resp_valid, prev_r);
      if (prev_r) chk("cont_resp_data", bus.rd_resp_data, prev_exp);
      bus.rd_req_valid = 1'b1;
      bus.rd_req_addr  = ra;
      bus.wr_req_valid = 1'b1;
      bus.wr_req_addr  = wa;
      bus.wr_req_data  = wd;
      bus.wr_req_mask  = 6'h3F;
      #1;
      prev_r = (k % 5 == 4);
      chk("cont_grant", {bus.wr_req_ready, bus.rd_req_ready, sram_wmode}, prev_r ? 3'b010 : 3'b101);
      if (prev_r) begin
        prev_exp = ref_get(int'(ra));
        rd_idx++;
        ra = ADDR_W'(32'h100 + rd_idx);
      end else begin
        ref_write(int'(wa), wd, 6'h3F);
        wa = wa + ADDR_W'(1);
        wd = rnd_data();
      end
      @(negedge clock); #1;
    end
    idle();
    chk("cont_last_resp", bus.rd_resp_valid, 1'b1);
    chk("cont_last_data", bus.rd_resp_data, prev_exp);
    do_read(ADDR_W'(32'h200));

    // Reset during a read fire: the pending response must be dropped.
    bus.rd_req_valid = 1'b1;
    bus.rd_req_addr  = ADDR_W'(5);
    reset = 1'b1;
    @(negedge clock); #1;
    idle();
    chk("rst_mid_read", {bus.rd_resp_valid, init_done}, 2'b00);
    reset = 1'b0;
    zero_filled = 1'b0;
    if (InitEn) begin
      startup(3000, 1'b0);
      reset = 1'b1;
      @(negedge clock); #1;
      reset = 1'b0;
      startup(DEPTH, 1'b1);
      do_read(ADDR_W'(5));
      chk("recleared_5", last_rdata, '0);
    end else begin
      startup(0, 1'b1);
      p = rnd_data();
      do_write(ADDR_W'(8191), p, 6'h3F);
      do_read(ADDR_W'(8191));
      chk("post_reset_rw", last_rdata, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_rw_arbiter.md
# sram_rw_arbiter

Controller for the 8192 x 174-bit single-port `RW0` data array: one `sram_*` port pair, 13-bit address, 6 x 29-bit write-mask lanes, 1-cycle registered read. It shares the single RW port between one read requester and one write requester. Writes have priority, with a bounded read-starvation guarantee. It optionally performs a hardware zero-clear sweep of the whole array after reset, and returns read data with fixed 1-cycle latency.

## Interface
- `ADDR_W`, 13, array address width
- `DATA_W`, 174, array data width
- `MASK_W`, 6, write-mask lanes (29 bits each)
- `DEPTH`, 8192, array entries
- `STARVE_LIMIT`, 4, consecutive read losses before the read is forced through
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `rd_req_valid` / `rd_req_ready`  in/out  1  read request handshake
- `rd_req_addr`  in  ADDR_W  read address
- `rd_resp_valid`  out  1  read data valid pulse; no backpressure
- `rd_resp_data`  out  DATA_W  read data
- `wr_req_valid` / `wr_req_ready`  in/out  1  write request handshake
- `wr_req_addr`  in  ADDR_W  write address
- `wr_req_data`  in  DATA_W  write data
- `wr_req_mask`  in  MASK_W  per-lane write enable
- `init_done`  out  1  high once the array is accepting requests
- `sram_en`, `sram_wmode`  out  1  to array `RW0_en`, `RW0_wmode`
- `sram_addr`  out  ADDR_W  to `RW0_addr`
- `sram_wmask`  out  MASK_W  to `RW0_wmask`
- `sram_wdata`  out  DATA_W  to `RW0_wdata`
- `sram_rdata`  in  DATA_W  from `RW0_rdata`

## Operation
- States: INIT (clear sweep) and RUN. Reset forces INIT with `init_cnt`=0 when `SRAM_ARB_INIT_EN` is defined, and RUN otherwise.
- **INIT:**
  - Each cycle: `sram_en`=1, `wmode`=1, `wmask`=all ones, `wdata`=0, `addr`=`init_cnt`; then `init_cnt`++.
  - After address DEPTH-1 is written, go to RUN.
  - Both readies are 0 in INIT.
- **RUN, arbitration** (fire = valid && ready):
  - `wr_req_ready` = RUN && !(`rd_req_valid` && `starve_hit`)
  - `rd_req_ready` = RUN && (!`wr_req_valid` || `starve_hit`)
  - `starve_hit` = (`starve_cnt` == STARVE_LIMIT)
- **Starvation counter:**
  - Increments when `rd_req_valid` && write fire, saturating at STARVE_LIMIT.
  - Clears on read fire.
  - Holds otherwise.
- **Array drive:**
  - On write fire: `sram_en`=1, `wmode`=1, with addr/mask/data taken from the write request.
  - On read fire: `sram_en`=1, `wmode`=0, `addr`=`rd_req_addr`.
  - Otherwise `sram_en`=0 and the other sram outputs are don't-care (driven to 0).
- **Response path:**
  - `rd_resp_valid` is read fire registered by one cycle.
  - `rd_resp_data` = `sram_rdata` combinationally; it is only meaningful while `rd_resp_valid`=1.
- Write-then-read to the same address in consecutive cycles returns the new data. The array is serialized, so no bypass is needed.

## Timing
- Reset values: `rd_resp_valid`=0, `init_done`=0, both readies 0, `sram_en`=0, `starve_cnt`=0.
- Read latency: request fires in cycle N; `rd_resp_valid`=1 with data in cycle N+1. Back-to-back reads give one response per cycle.
- Write takes effect at the clock edge ending the fire cycle.
- `init_done` is registered:
  - With init: it rises the cycle after the last clear write, i.e. DEPTH+1 cycles after reset deasserts.
  - Without init: it rises 1 cycle after reset deasserts, and RUN is entered the same cycle.
- Simultaneous valid with `starve_cnt`<LIMIT: the write wins.
- Simultaneous valid with `starve_cnt`==LIMIT: the read wins, and the counter clears on the next edge.
- Reset asserted mid-INIT or mid-read: INIT restarts at address 0 (or RUN is entered without init), and any pending `rd_resp_valid` is cleared on the next edge.
- Requesters must hold `valid` and payload stable until fire.

## Configuration
- `SRAM_ARB_INIT_EN` defined: reset enters INIT and the full zero-clear sweep runs (DEPTH cycles).
- `SRAM_ARB_INIT_EN` undefined: no INIT state and no `init_cnt` logic; array contents are undefined after reset, and RUN is entered immediately.

## Structure
- Package `sram_arb_pkg`:
  - Width/depth localparams (ADDR_W, DATA_W, MASK_W, DEPTH).
  - State enum `{ARB_INIT, ARB_RUN}`.
  - A request struct `{addr, data, mask}`.
- Sub-module `sram_init_seq`: address counter plus done flag, instantiated only under `SRAM_ARB_INIT_EN`. Arbitration and the response register stay in the top module.

## Test plan
- Init sweep (macro on): release reset → `sram_en`/`wmode` high for exactly 8192 cycles at addresses 0..8191 with mask 6'h3F and data 0; `init_done` rises on cycle 8193; a read of 0x1ABC then returns 0.
- Write/read: write 0x0005 with data pattern P and mask 6'h3F, then read 0x0005 → `rd_resp_valid` one cycle after the read fire, data == P.
- Masked write: after full write P, write Q to the same address with mask 6'b000010 → read returns P with bits [57:29] replaced by Q[57:29].
- Contention (STARVE_LIMIT=4): hold both valids continuously → grant pattern W,W,W,W,R repeating; no read waits more than 5 cycles.
- Reset mid-INIT: assert reset at init address 3000 for 1 cycle → sweep restarts at 0; `init_done` is only high 8193 cycles after the second release.
- Back-to-back reads: 0x10, 0x11, 0x12 on consecutive cycles → three consecutive `rd_resp_valid` pulses with the matching data.
